// File: rtl/shift165_pkg.sv
// Shared constants and helpers for the shift165_chain 74x165 cascade emulator.
package shift165_pkg;

  localparam int SYNC_STAGES = 2;

  localparam logic RST_SYNC_BIT   = 1'b0;
  localparam logic RST_FRAME_DONE = 1'b0;

  function automatic int cnt_w(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/shift165_chain_if.sv
// Parallel-load / serial-read bus of shift165_chain.
// SHIFT165_CLKINH_EN adds the clk_inh shift-inhibit input.
interface shift165_chain_if
  import shift165_pkg::*;
#(
  parameter int TOTAL = 16
);
  localparam int CW = cnt_w(TOTAL);

  logic [TOTAL-1:0] par_in;
  logic             shld_n;
  logic             serclk;
  logic             ser_in;
`ifdef SHIFT165_CLKINH_EN
  logic             clk_inh;
`endif
  logic             q7;
  logic             q7_n;
  logic [CW-1:0]    bit_cnt;
  logic             frame_done;

  modport master (
    output par_in, shld_n, serclk, ser_in,
`ifdef SHIFT165_CLKINH_EN
    output clk_inh,
`endif
    input  q7, q7_n, bit_cnt, frame_done
  );

  modport slave (
    input  par_in, shld_n, serclk, ser_in,
`ifdef SHIFT165_CLKINH_EN
    input  clk_inh,
`endif
    output q7, q7_n, bit_cnt, frame_done
  );

endinterface

// File: rtl/shift165_chain_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input, giving the synchronised
// level and a one-clk pulse on its rising edge.
module sync_edge_det
  import shift165_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  // STAGES synchroniser flops plus one history flop for edge detection.
  logic [STAGES:0] sh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= {(STAGES + 1){RST_SYNC_BIT}};
    else     sh <= {sh[STAGES-1:0], async_in};
  end

  assign level = sh[STAGES-1];
  assign rise  = sh[STAGES-1] & ~sh[STAGES];

endmodule

// File: rtl/shift165_chain.sv
// DEVICES cascaded 74x165 PISO shifters clocked from a synchronised serclk,
// with load holdoff, bit counter and frame-done pulse. Option: SHIFT165_CLKINH_EN.
module shift165_chain
  import shift165_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEVICES = 1,
  parameter int HOLDOFF = 1
) (
  input logic             clk,
  input logic             rst,
  shift165_chain_if.slave bus
);

  localparam int TOTAL = WIDTH * DEVICES;
  localparam int CW    = cnt_w(TOTAL);
  localparam int HW    = $clog2(HOLDOFF + 1);

  logic [TOTAL-1:0] store;
  logic [CW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             frame_done;
  logic             serclk_rise;
  logic             ser_in_sync;
  logic             shift_en;
  logic             serclk_level_unused;
  logic             ser_in_rise_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_serclk (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.serclk),
    .level    (serclk_level_unused),
    .rise     (serclk_rise)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ser_in (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.ser_in),
    .level    (ser_in_sync),
    .rise     (ser_in_rise_unused)
  );

`ifdef SHIFT165_CLKINH_EN
  logic clk_inh_sync;
  logic clk_inh_rise_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_clk_inh (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.clk_inh),
    .level    (clk_inh_sync),
    .rise     (clk_inh_rise_unused)
  );

  assign shift_en = serclk_rise & ~clk_inh_sync;
`else
  assign shift_en = serclk_rise;
`endif

  // Load has priority; edges arriving during load or holdoff are dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store      <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= HW'(HOLDOFF);
      frame_done <= RST_FRAME_DONE;
    end else if (!bus.shld_n) begin
      store      <= bus.par_in;
      bit_cnt    <= '0;
      hold_cnt   <= HW'(HOLDOFF);
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else if (shift_en) begin
        store      <= {store[TOTAL-2:0], ser_in_sync};
        if (bit_cnt != CW'(TOTAL)) bit_cnt <= bit_cnt + 1'b1;
        frame_done <= (bit_cnt == CW'(TOTAL - 1));
      end
    end
  end

  assign bus.q7         = store[TOTAL-1];
  assign bus.q7_n       = ~store[TOTAL-1];
  assign bus.bit_cnt    = bit_cnt;
  assign bus.frame_done = frame_done;

endmodule
